// File: rtl/reg_in_fifo.sv
// reg_in_fifo: first-word-fall-through synchronous FIFO that buffers producer
// words ahead of the register stage. All status flags are decoded from the
// registered occupancy count, so no handshake input reaches them combinationally.
module reg_in_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4,
  parameter int CWIDTH = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DWIDTH-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DWIDTH-1:0] m_data_o,
  output logic [CWIDTH-1:0] count_o,
  output logic              almost_full_o
);

  localparam int AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_reg;
  logic [AWIDTH-1:0] rd_ptr_reg;
  logic [CWIDTH-1:0] count_reg;
  logic [CWIDTH-1:0] count_next;
  logic              push;
  logic              pop;
  logic              clear;

  // Handshakes qualify only against registered status, never against each other.
  assign push  = s_valid_i && s_ready_o;
  assign pop   = m_valid_o && m_ready_i;
  assign clear = rst_i || flush_i;

  assign s_ready_o     = (count_reg != CWIDTH'(DEPTH));
  assign m_valid_o     = (count_reg != '0);
  assign almost_full_o = (count_reg >= CWIDTH'(DEPTH - 1));
  assign count_o       = count_reg;

  // Head word falls through; forced to zero whenever the FIFO is empty.
  assign m_data_o = m_valid_o ? mem[rd_ptr_reg] : '0;

  // Storage write; contents are deliberately left untouched by reset or flush.
  always_ff @(posedge clk_i) begin
    if (push && !clear) begin
      mem[wr_ptr_reg] <= s_data_i;
    end
  end

  // Occupancy arithmetic: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CWIDTH'(1);
      2'b01:   count_next = count_reg - CWIDTH'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and count registers; reset and flush both win over any handshake.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AWIDTH'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AWIDTH'(1);
      count_reg <= count_next;
    end
  end

endmodule
